// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART command-frame parser: FSM state encodings,
// error codes and the default frame start marker.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN_BAD = 2'd1;
  localparam logic [1:0] ERR_CHK_BAD = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // True while a frame is partially received and the inter-byte timer must run.
  function automatic logic isMidFrame(input logic [2:0] st);
    return (st == ST_CMD) || (st == ST_LEN) || (st == ST_PAYLOAD) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog for UART-side blocks. Counts enabled cycles since the
// last clear and flags the cycle on which the count reaches TIMEOUT_CLKS-1.
// A clear on that same cycle suppresses the expiry, so a late byte still wins.
module uart_byte_timeout #(
  parameter int TIMEOUT_CLKS = 5000
) (
  input  logic i_Clock,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int CntW = $clog2(TIMEOUT_CLKS);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CLKS - 1);

  logic [CntW-1:0] count_q, count_d;

  // Next count: restart on clear, when disabled, or after reaching the limit.
  always_comb begin
    count_d = count_q;
    if (i_Clear || !i_Enable) begin
      count_d = '0;
    end else if (count_q == LastCount) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Expire = i_Enable && !i_Clear && (count_q == LastCount);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Assembles SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART receiver byte
// strobe, holds checksum-valid frames under a valid/ack handshake and
// reports protocol errors as one-cycle coded pulses.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 5000,
  localparam int        ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Rst,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Frame_Ack,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic              o_Frame_Valid,
  output logic [7:0]        o_Frame_Cmd,
  output logic [7:0]        o_Frame_Len,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Err_Pulse,
  output logic [1:0]        o_Err_Code
);

  localparam logic [7:0]      MaxLenByte = 8'(MAX_LEN);
  localparam logic [ADDR_W:0] MaxLenAddr = (ADDR_W + 1)'(MAX_LEN);

  logic [2:0] state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] idx_q, idx_d;
  logic       errPulse_q, errPulse_d;
  logic [1:0] errCode_q, errCode_d;
  logic       bufWe;
  logic [7:0] payloadBuf_q [MAX_LEN];

  logic              toExpire;
  logic [ADDR_W-1:0] writeAddr;

  assign writeAddr = idx_q[ADDR_W-1:0];

  uart_byte_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock (i_Clock),
    .i_Rst   (i_Rst),
    .i_Clear (i_Rx_DV),
    .i_Enable(isMidFrame(state_q)),
    .o_Expire(toExpire)
  );

  // Frame FSM: every transition is driven by a byte strobe except timeout
  // expiry, which only fires on strobe-free cycles and so never collides.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    errPulse_d = 1'b0;
    errCode_d  = 2'd0;
    bufWe      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          sum_d   = i_Rx_Byte;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte > MaxLenByte) begin
            errPulse_d = 1'b1;
            errCode_d  = ERR_LEN_BAD;
            state_d    = ST_IDLE;
          end else begin
            len_d   = i_Rx_Byte;
            sum_d   = sum_q + i_Rx_Byte;
            idx_d   = 8'd0;
            state_d = (i_Rx_Byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          bufWe = 1'b1;
          sum_d = sum_q + i_Rx_Byte;
          idx_d = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == sum_q) begin
            state_d = ST_HOLD;
          end else begin
            errPulse_d = 1'b1;
            errCode_d  = ERR_CHK_BAD;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (i_Rx_DV) begin
          errPulse_d = 1'b1;
          errCode_d  = ERR_OVERRUN;
        end
        if (i_Frame_Ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (toExpire) begin
      state_d    = ST_IDLE;
      errPulse_d = 1'b1;
      errCode_d  = ERR_TIMEOUT;
    end
  end

  // State, header, checksum and payload registers.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      len_q      <= 8'h00;
      sum_q      <= 8'h00;
      idx_q      <= 8'h00;
      errPulse_q <= 1'b0;
      errCode_q  <= 2'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        payloadBuf_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      errPulse_q <= errPulse_d;
      errCode_q  <= errCode_d;
      if (bufWe) begin
        payloadBuf_q[writeAddr] <= i_Rx_Byte;
      end
    end
  end

  assign o_Frame_Valid = (state_q == ST_HOLD);
  assign o_Frame_Cmd   = cmd_q;
  assign o_Frame_Len   = len_q;
  assign o_Err_Pulse   = errPulse_q;
  assign o_Err_Code    = errCode_q;
  assign o_Rd_Data     = ({1'b0, i_Rd_Addr} < MaxLenAddr) ? payloadBuf_q[i_Rd_Addr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: stimulus pushes the expected
// frame/error events, an independent monitor pops them as the DUT reports.
module tb_uart_rx_frame_parser;
  import uart_frame_pkg::*;

  localparam int MaxLen      = 12;
  localparam int TimeoutClks = 40;
  localparam int AddrW       = 4;
  localparam logic [7:0] Sync = 8'hA5;

  typedef struct packed {
    logic             kind;   // 1 = error event, 0 = frame event
    logic [1:0]       code;
    logic [7:0]       cmd;
    logic [7:0]       len;
    logic [15:0][7:0] pay;
  } expEvent_t;

  logic             i_Clock;
  logic             i_Rst;
  logic             i_Rx_DV;
  logic [7:0]       i_Rx_Byte;
  logic             i_Frame_Ack;
  logic [AddrW-1:0] i_Rd_Addr;
  logic             o_Frame_Valid;
  logic [7:0]       o_Frame_Cmd;
  logic [7:0]       o_Frame_Len;
  logic [7:0]       o_Rd_Data;
  logic             o_Err_Pulse;
  logic [1:0]       o_Err_Code;

  expEvent_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  uart_rx_frame_parser #(
    .SYNC_BYTE   (Sync),
    .MAX_LEN     (MaxLen),
    .TIMEOUT_CLKS(TimeoutClks)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst        (i_Rst),
    .i_Rx_DV      (i_Rx_DV),
    .i_Rx_Byte    (i_Rx_Byte),
    .i_Frame_Ack  (i_Frame_Ack),
    .i_Rd_Addr    (i_Rd_Addr),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Frame_Cmd  (o_Frame_Cmd),
    .o_Frame_Len  (o_Frame_Len),
    .o_Rd_Data    (o_Rd_Data),
    .o_Err_Pulse  (o_Err_Pulse),
    .o_Err_Code   (o_Err_Code)
  );

  // Free-running clock, period 100.
  initial i_Clock = 1'b0;
  always #50 i_Clock = ~i_Clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference checksum straight from the frame definition.
  function automatic logic [7:0] checksumOf(input logic [7:0] cmd, input logic [7:0] len,
                                            input logic [15:0][7:0] pay);
    int s;
    s = int'(cmd) + int'(len);
    for (int i = 0; i < int'(len); i++) s += int'(pay[i]);
    return 8'(s % 256);
  endfunction

  task automatic pushFrame(input logic [7:0] cmd, input logic [7:0] len, input logic [15:0][7:0] pay);
    expEvent_t e;
    e.kind = 1'b0; e.code = 2'd0; e.cmd = cmd; e.len = len; e.pay = pay;
    expQ.push_back(e);
  endtask

  task automatic pushErr(input logic [1:0] code);
    expEvent_t e;
    e = '0;
    e.kind = 1'b1; e.code = code;
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    #1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'($urandom);
  endtask

  // Sends the first 'count' bytes of SYNC,CMD,LEN,PAYLOAD[len],CHK.
  task automatic sendSeq(input logic [7:0] cmd, input logic [7:0] len, input logic [15:0][7:0] pay,
                         input logic [7:0] chk, input int count, input int maxGap);
    logic [7:0] bytes[$];
    bytes.push_back(Sync);
    bytes.push_back(cmd);
    bytes.push_back(len);
    for (int i = 0; i < int'(len) && i < 16; i++) bytes.push_back(pay[i]);
    bytes.push_back(chk);
    for (int i = 0; i < count && i < bytes.size(); i++) begin
      sendByte(bytes[i]);
      idleCycles(int'($urandom_range(0, maxGap)));
    end
  endtask

  task automatic ackPulse();
    i_Frame_Ack = 1'b1;
    @(posedge i_Clock);
    #1;
    i_Frame_Ack = 1'b0;
    checkOutput("validDrop", 64'(o_Frame_Valid), 64'd0);
  endtask

  // Waits for the held frame, optionally provokes an overrun, then releases it.
  task automatic holdAndRelease(input int mode);
    for (int k = 0; k < 8 && !o_Frame_Valid; k++) idleCycles(1);
    checkOutput("frameWait", 64'(o_Frame_Valid), 64'd1);
    idleCycles(1);
    if (mode == 1) begin
      pushErr(ERR_OVERRUN);
      sendByte(8'($urandom));
      checkOutput("overrunHold", 64'(o_Frame_Valid), 64'd1);
      idleCycles(1);
      ackPulse();
    end else if (mode == 2) begin
      pushErr(ERR_OVERRUN);
      i_Frame_Ack = 1'b1;
      i_Rx_DV     = 1'b1;
      i_Rx_Byte   = 8'($urandom);
      @(posedge i_Clock);
      #1;
      i_Frame_Ack = 1'b0;
      i_Rx_DV     = 1'b0;
      checkOutput("validDropOverrun", 64'(o_Frame_Valid), 64'd0);
    end else begin
      idleCycles(int'($urandom_range(0, 3)));
      ackPulse();
    end
  endtask

  // kind: 0 good, 1 bad checksum, 2 bad length, 3 timeout, 4 strobe on expiry cycle.
  task automatic applyStimulus(input int kind, input logic [7:0] cmd, input logic [7:0] len,
                               input logic [15:0][7:0] pay, input int holdMode);
    logic [7:0] chk;
    logic [7:0] badLen;
    chk = checksumOf(cmd, len, pay);
    case (kind)
      0: begin
        pushFrame(cmd, len, pay);
        sendSeq(cmd, len, pay, chk, 4 + int'(len), 2);
        holdAndRelease(holdMode);
      end
      1: begin
        pushErr(ERR_CHK_BAD);
        sendSeq(cmd, len, pay, chk + 8'($urandom_range(1, 255)), 4 + int'(len), 2);
        idleCycles(2);
      end
      2: begin
        badLen = 8'($urandom_range(MaxLen + 1, 255));
        pushErr(ERR_LEN_BAD);
        sendSeq(cmd, badLen, pay, chk, 3, 2);
        idleCycles(2);
      end
      3: begin
        pushErr(ERR_TIMEOUT);
        sendSeq(cmd, len, pay, chk, int'($urandom_range(1, 3 + int'(len))), 2);
        idleCycles(TimeoutClks + 3);
      end
      default: begin
        pushFrame(cmd, len, pay);
        sendByte(Sync);
        sendByte(cmd);
        idleCycles(TimeoutClks - 1);
        sendByte(len);
        for (int i = 0; i < int'(len); i++) sendByte(pay[i]);
        sendByte(chk);
        holdAndRelease(holdMode);
      end
    endcase
  endtask

  // Monitor: pops the scoreboard on every error pulse and every new frame.
  logic             prevValid = 1'b0;
  logic [7:0]       heldCmd   = 8'h00;
  logic [7:0]       heldLen   = 8'h00;
  logic [15:0][7:0] heldPay   = '0;

  task automatic readBack();
    for (int i = 0; i < 16; i++) begin
      i_Rd_Addr = AddrW'(i);
      #2;
      if (i < int'(heldLen)) checkOutput("rdPayload", 64'(o_Rd_Data), 64'(heldPay[i]));
      else if (i >= MaxLen) checkOutput("rdOutOfRange", 64'(o_Rd_Data), 64'd0);
    end
    i_Rd_Addr = '0;
  endtask

  always @(negedge i_Clock) begin
    expEvent_t e;
    if (o_Err_Pulse) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedErr", 64'({o_Err_Pulse, o_Err_Code}), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("errEvent", 64'({o_Err_Pulse, o_Err_Code}), 64'({e.kind, e.code}));
      end
      if (o_Frame_Valid && prevValid) readBack();
    end
    if (o_Frame_Valid && !prevValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFrame", 64'(o_Frame_Valid), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("frameEvent", 64'({o_Frame_Valid, o_Frame_Cmd, o_Frame_Len}),
                    64'({~e.kind, e.cmd, e.len}));
        heldCmd = e.cmd;
        heldLen = e.len;
        heldPay = e.pay;
        readBack();
      end
    end else if (o_Frame_Valid) begin
      checkOutput("heldStable", 64'({o_Frame_Cmd, o_Frame_Len}), 64'({heldCmd, heldLen}));
    end
    prevValid = o_Frame_Valid;
  end

  // Global time bound.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test-plan sequences followed by randomized frames.
  initial begin
    logic [15:0][7:0] pay;
    logic [7:0] cmd, len, junk;
    int kind;

    i_Rst = 1'b1; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Frame_Ack = 1'b0; i_Rd_Addr = '0;
    @(posedge i_Clock);
    #1;
    idleCycles(2);
    checkOutput("rstState", 64'({o_Frame_Valid, o_Frame_Cmd, o_Frame_Len, o_Rd_Data, o_Err_Pulse, o_Err_Code}), 64'd0);
    i_Rst = 1'b0;
    idleCycles(2);

    // Good frame A5 10 02 11 22 45.
    pay = '0; pay[0] = 8'h11; pay[1] = 8'h22;
    checkOutput("refChecksum", 64'(checksumOf(8'h10, 8'h02, pay)), 64'h45);
    applyStimulus(0, 8'h10, 8'h02, pay, 0);
    // Bad checksum 46, then a good frame.
    applyStimulus(1, 8'h10, 8'h02, pay, 0);
    applyStimulus(0, 8'h10, 8'h02, pay, 0);
    // Length too large: A5 07 11.
    pushErr(ERR_LEN_BAD);
    sendByte(Sync); sendByte(8'h07); sendByte(8'h11);
    idleCycles(2);
    // Junk then zero-length frame A5 07 00 07.
    sendByte(8'h00); sendByte(8'hFF);
    idleCycles(2);
    applyStimulus(0, 8'h07, 8'h00, pay, 0);
    // Timeout after A5 10 with exact pulse timing.
    pushErr(ERR_TIMEOUT);
    sendByte(Sync); sendByte(8'h10);
    idleCycles(TimeoutClks - 1);
    checkOutput("timeoutEarly", 64'(o_Err_Pulse), 64'd0);
    idleCycles(1);
    checkOutput("timeoutFire", 64'({o_Err_Pulse, o_Err_Code}), 64'({1'b1, ERR_TIMEOUT}));
    idleCycles(2);
    // Strobe landing on the expiry cycle continues the frame.
    applyStimulus(4, 8'h10, 8'h02, pay, 0);
    // Overrun, without and with a simultaneous ack, then normal parsing.
    pay[2] = Sync; pay[3] = 8'h3C;
    applyStimulus(0, 8'h42, 8'h04, pay, 1);
    applyStimulus(0, 8'h43, 8'h04, pay, 2);
    applyStimulus(0, 8'h44, 8'h03, pay, 0);
    // Reset in the middle of the payload.
    sendByte(Sync); sendByte(8'h5C); sendByte(8'h04); sendByte(8'h77);
    #2;
    i_Rst = 1'b1;
    #1;
    checkOutput("midRstOutputs", 64'({o_Frame_Valid, o_Frame_Cmd, o_Frame_Len, o_Rd_Data, o_Err_Pulse}), 64'd0);
    @(posedge i_Clock);
    #1;
    checkOutput("midRstNoErr", 64'(o_Err_Pulse), 64'd0);
    i_Rst = 1'b0;
    idleCycles(2);
    checkOutput("postRstNoErr", 64'(o_Err_Pulse), 64'd0);
    applyStimulus(0, 8'h10, 8'h02, pay, 0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom);
      len = 8'($urandom_range(0, MaxLen));
      for (int i = 0; i < 16; i++) pay[i] = ($urandom_range(0, 7) == 0) ? Sync : 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == Sync) junk = 8'h00;
        sendByte(junk);
      end
      kind = int'($urandom_range(0, 9));
      if (kind > 4) kind = 0;
      applyStimulus(kind, cmd, len, pay, int'($urandom_range(0, 2)));
    end

    idleCycles(10);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
Sits directly downstream of the UART receiver. It consumes its one-cycle byte strobe and byte bus, and assembles framed command packets: SYNC, CMD, LEN, PAYLOAD[LEN], CHK. A frame is presented only if its checksum is valid. The frame is held under a valid/ack handshake, with payload read through a random-access port. Errors are reported as one-cycle pulses with a code. It feeds the IR test command logic.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 16, maximum payload bytes (1..255).
TIMEOUT_CLKS, 5000, inter-byte timeout in i_Clock cycles while mid-frame (>=2).
ADDR_W, derived localparam = clog2(MAX_LEN), minimum 1; not user-set.

Ports:
i_Clock  in  1  system clock
i_Rst  in  1  reset
i_Rx_DV  in  1  one-cycle byte-valid strobe from UART receiver
i_Rx_Byte  in  8  received byte, qualified by i_Rx_DV
i_Frame_Ack  in  1  consumer releases held frame
i_Rd_Addr  in  ADDR_W  payload read index
o_Frame_Valid  out  1  good frame held
o_Frame_Cmd  out  8  CMD byte of held frame
o_Frame_Len  out  8  LEN byte of held frame
o_Rd_Data  out  8  payload byte at i_Rd_Addr (combinational)
o_Err_Pulse  out  1  one-cycle error strobe
o_Err_Code  out  2  0 OVERRUN, 1 LEN_BAD, 2 CHK_BAD, 3 TIMEOUT; valid only with o_Err_Pulse

Behaviour:
- Interface: reset i_Rst, asynchronous, active-high; clock i_Clock.
- Reset values: all outputs 0, payload buffer cleared, state IDLE, sum 0, timeout counter 0.
- Reset asserted mid-frame aborts the frame silently, with no error pulse.
- Checksum: 8-bit running sum (mod 256) of CMD, LEN and all payload bytes. SYNC and CHK are excluded.
- States and transitions (all advance only on a cycle where i_Rx_DV=1):
  - IDLE: byte==SYNC_BYTE -> CMD. Any other byte is ignored with no error.
  - CMD: latch cmd; sum=byte -> LEN.
  - LEN: if byte>MAX_LEN -> error LEN_BAD, go to IDLE. Otherwise latch len, sum+=byte, idx=0. Go to CHK if byte==0, else PAYLOAD.
  - PAYLOAD: buf[idx]=byte, sum+=byte, idx++. After the byte with idx==len-1 -> CHK. SYNC_BYTE values here are plain data; there is no resync.
  - CHK: if byte==sum -> HOLD, else error CHK_BAD -> IDLE.
  - HOLD: o_Frame_Valid=1. i_Frame_Ack=1 -> IDLE; o_Frame_Valid falls the next cycle. i_Frame_Ack outside HOLD is ignored.
- Latency: o_Frame_Valid rises the cycle after the CHK-byte strobe. Error pulses occur the cycle after the offending strobe or timeout expiry.
- o_Frame_Cmd, o_Frame_Len and the buffer are stable throughout HOLD. They update only on the next frame's CMD, LEN and PAYLOAD bytes.
- Overrun: any i_Rx_DV in HOLD, including the same cycle as i_Frame_Ack, drops the byte and pulses OVERRUN. Held contents are unchanged.
- Timeout:
  - Counter runs only in CMD, LEN, PAYLOAD and CHK; cleared on every i_Rx_DV and in IDLE/HOLD.
  - When the counter reaches TIMEOUT_CLKS-1 with no strobe: error TIMEOUT, go to IDLE.
  - A strobe arriving on the expiry cycle wins: the byte is processed and there is no timeout.
- o_Rd_Data = buf[i_Rd_Addr] when i_Rd_Addr<MAX_LEN, else 8'h00. Data beyond len is stale but defined.
- Only one error can occur per cycle; codes are mutually exclusive by state.

Decomposition:
- Package uart_frame_pkg: state encodings (IDLE, CMD, LEN, PAYLOAD, CHK, HOLD), error code constants, default SYNC_BYTE.
- Sub-module uart_byte_timeout: loadable counter with clear input, enable input and one-cycle expire output. It is parameterised by TIMEOUT_CLKS and reusable by other UART-side blocks.

Test Plan:
- Good frame: A5 10 02 11 22 45 -> o_Frame_Valid=1, Cmd=10, Len=02, Rd[0]=11, Rd[1]=22, no error; ack -> Valid=0 next cycle.
- Bad checksum: A5 10 02 11 22 46 -> Err_Pulse with code 2, Valid stays 0. A following good frame is accepted.
- Length and zero-length:
  - A5 07 11 -> code 1 (17>16).
  - A5 07 00 07 -> Valid with Len=0.
  - Leading junk bytes 00 FF before A5 produce no error.
- Timeout: A5 10, then silence for TIMEOUT_CLKS cycles -> code 3 on the expiry cycle+1, state back to IDLE. A strobe on the expiry cycle instead continues the frame.
- Overrun: good frame held, then byte 33 strobed (also tested with ack in the same cycle) -> code 0. Cmd, Len and buffer unchanged; the next frame parses normally.
- Reset: assert i_Rst mid-PAYLOAD -> all outputs 0 immediately with no error pulse. After release, a full good frame parses correctly.
